arbitro_memoria: RTL
====================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cpu_req  input  1  CPU (control unit REM/RDM path) access request, level.
REQ-006 cpu_we  input  1  CPU request is a write (1) or read (0).
REQ-007 cpu_addr  input  ADDR_W  CPU address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  output  DATA_W  CPU read data, valid while cpu_ack=1.
REQ-011 dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  I/O-DMA port, same meaning as CPU port.
REQ-012 dma_ack  output  1; dma_rdata  output  DATA_W  same meaning as CPU port.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address and write data.
REQ-016 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after the mem_en cycle.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, CAPTURE, ACK; transitions IDLE->ACCESS on grant, ACCESS->CAPTURE, CAPTURE->ACK, ACK->IDLE unconditionally.
REQ-019 In IDLE with no request, FSM SHALL stay in IDLE; mem_en, mem_we, both acks SHALL be 0.
REQ-020 Grant rule in IDLE: only one req high -> grant it; both high -> grant the port not recorded in last_grant; last_grant updated at the grant edge.
REQ-021 At grant edge, the arbiter SHALL latch the winner's we/addr/wdata; later changes on the request inputs SHALL have no effect until ACK.
REQ-022 In ACCESS, mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, all registered; mem_en=0 and mem_we=0 in every other state.
REQ-023 In CAPTURE, for a read, mem_rdata SHALL be registered into the winner's rdata register at the CAPTURE->ACK edge.
REQ-024 In ACK, only the winner's ack SHALL be 1, for exactly one cycle.
REQ-025 Latency: req sampled high at edge k -> mem_en high cycle k+1 -> ack high cycle k+3; total 4 cycles per access including return to IDLE.
REQ-026 Requesters SHALL hold req and operands until ack and drop req in the cycle after ack; the arbiter samples req again only in IDLE, so a dropped req is never re-granted.
REQ-027 A request held high past its ack SHALL be treated as a new request (back-to-back access allowed), subject to REQ-020.
REQ-028 On writes, rdata of the winner SHALL keep its previous value; the other port's rdata SHALL never change.
REQ-029 With both ports requesting continuously, grants SHALL alternate CPU, DMA, CPU, ...; no port waits more than one foreign access.
REQ-030 A req asserted while busy=1 SHALL wait, never abort or alter the ongoing access.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, busy=0, last_grant=DMA (CPU wins first tie).
REQ-032 Reset during ACCESS SHALL drop mem_we asynchronously; the aborted access produces no ack after reset release.
REQ-033 After rst_n rises, first grant decision SHALL occur at the first posedge clk with rst_n=1.

Verification
REQ-034 CPU read addr 0x10 (mem[0x10]=0xA5), DMA idle -> mem_en at k+1 with mem_addr=0x10, cpu_ack at k+3 with cpu_rdata=0xA5, dma_ack stays 0.
REQ-035 DMA write 0x3C to 0x80 -> mem_en=mem_we=1, mem_addr=0x80, mem_wdata=0x3C for one cycle; dma_ack at k+3; dma_rdata unchanged.
REQ-036 Both req high same edge after reset -> CPU granted first, DMA granted at the IDLE edge after CPU's ack; next simultaneous pair -> CPU again (alternation).
REQ-037 Change cpu_addr 0x10->0x20 during ACCESS -> mem_addr stays 0x10, read data from 0x10 returned.
REQ-038 Assert rst_n=0 mid-ACCESS of a write -> mem_we=0 same cycle, no ack after release, busy=0, all outputs at reset values.

Source files
------------

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-port (CPU / DMA) arbiter in front of a single
// synchronous memory. One access at a time, four cycles per access.
// On simultaneous requests the port that did not win last time is granted,
// so continuous contention alternates between the two ports.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access in flight; requests are sampled here only
// ACCESS  | mem_en driven with the latched winner operands
// CAPTURE | memory read data is valid; registered into winner rdata
// ACK     | one-cycle ack to the winner
module arbitro_memoria #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t state, state_nx;

  // last_grant doubles as the winner of the access in flight (1 = DMA)
  logic              last_grant;
  logic              lat_we;
  logic              grant;
  logic              grant_dma;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // grant decision: only evaluated in IDLE, tie goes to the port not served last
  always_comb begin
    grant     = 1'b0;
    grant_dma = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && dma_req) begin
        grant     = 1'b1;
        grant_dma = ~last_grant;
      end else if (cpu_req) begin
        grant     = 1'b1;
        grant_dma = 1'b0;
      end else if (dma_req) begin
        grant     = 1'b1;
        grant_dma = 1'b1;
      end
    end
  end

  // winner operand mux
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACCESS;
      ACCESS:  state_nx = CAPTURE;
      CAPTURE: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // latch winner identity and operands at the grant edge; held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (grant) begin
      last_grant <= grant_dma;
      lat_we     <= sel_we;
      mem_addr   <= sel_addr;
      mem_wdata  <= sel_wdata;
    end
  end

  // memory strobes are high only during ACCESS, which is entered solely from a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      mem_en <= grant;
      mem_we <= grant & sel_we;
    end
  end

  // ack pulse for the winner, raised on the CAPTURE->ACK edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
    end else begin
      cpu_ack <= (state == CAPTURE) && !last_grant;
      dma_ack <= (state == CAPTURE) &&  last_grant;
    end
  end

  // read data capture into the winner's register; writes leave both untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if ((state == CAPTURE) && !lat_we) begin
      if (last_grant) dma_rdata <= mem_rdata;
      else            cpu_rdata <= mem_rdata;
    end
  end

  assign busy = (state != IDLE);

endmodule
